// File: rtl/imm_ext_pkg.sv
// Shared types and default widths for the
// decode-stage immediate extender.
package imm_ext_pkg;

  localparam int IN_W_DEF    = 26;
  localparam int SHORT_W_DEF = 16;
  localparam int DATA_W_DEF  = 32;
  localparam int LANES_DEF   = 4;

  typedef enum logic [1:0] {
    SEXT_SHORT = 2'b00,
    SEXT_LONG  = 2'b01,
    ZEXT_SHORT = 2'b10,
    UPPER      = 2'b11
  } imm_mode_t;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b10
  } state_t;

  function automatic logic widths_ok(
    input int in_w,
    input int short_w,
    input int data_w,
    input int lanes
  );
    return (short_w < in_w) &&
           (in_w <= data_w) &&
           (lanes >= 1);
  endfunction

endpackage

// File: rtl/imm_extend_core.sv
// Combinational extension of one raw
// immediate to DATA_W for a given mode.
module imm_extend_core
  import imm_ext_pkg::*;
#(
  parameter int IN_W    = IN_W_DEF,
  parameter int SHORT_W = SHORT_W_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic [IN_W-1:0]   num_in,
  input  imm_mode_t         mode,
  output logic [DATA_W-1:0] ext
);

  localparam int LO_W = DATA_W - SHORT_W;

  logic [SHORT_W-1:0] short_imm;

  assign short_imm = num_in[SHORT_W-1:0];

  // select one of the four extension forms
  always_comb begin
    ext = '0;
    unique case (mode)
      SEXT_SHORT:
        ext = DATA_W'($signed(short_imm));
      SEXT_LONG:
        ext = DATA_W'($signed(num_in));
      ZEXT_SHORT:
        ext = DATA_W'(short_imm);
      UPPER:
        ext = {short_imm, {LO_W{1'b0}}};
      default:
        ext = '0;
    endcase
  end

endmodule

// File: rtl/imm_extend_unit.sv
// Registered immediate extender with lane
// broadcast and a one-entry skid buffer.
module imm_extend_unit
  import imm_ext_pkg::*;
#(
  parameter int IN_W    = IN_W_DEF,
  parameter int SHORT_W = SHORT_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int LANES   = LANES_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [IN_W-1:0]         num_in,
  input  logic [1:0]              imm_src,
  input  logic [LANES-1:0]        lane_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] num_out
);

  localparam int BUS_W = LANES * DATA_W;

  if (!widths_ok(IN_W, SHORT_W,
                 DATA_W, LANES)) begin : g_bad
    $fatal(1, "imm_extend_unit: bad widths");
  end

  state_t state;
  state_t state_nxt;

  logic [DATA_W-1:0] ext;
  logic [BUS_W-1:0]  lane_data;
  logic [BUS_W-1:0]  out_q;
  logic [BUS_W-1:0]  skid_q;

  logic accept;
  logic skid_valid;
  logic load_new;
  logic load_skid;
  logic pop_skid;

  imm_extend_core #(
    .IN_W   (IN_W),
    .SHORT_W(SHORT_W),
    .DATA_W (DATA_W)
  ) u_core (
    .num_in(num_in),
    .mode  (imm_mode_t'(imm_src)),
    .ext   (ext)
  );

  // broadcast the extended value, zeroing masked lanes
  always_comb begin
    lane_data = '0;
    for (int i = 0; i < LANES; i++) begin
      lane_data[i*DATA_W +: DATA_W] =
        lane_en[i] ? ext : '0;
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      EMPTY: begin
        if (accept) state_nxt = ONE;
      end
      ONE: begin
        if (accept && !out_ready)
          state_nxt = FULL;
        else if (!accept && out_ready)
          state_nxt = EMPTY;
      end
      FULL: begin
        if (out_ready) state_nxt = ONE;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // handshake outputs and register load enables
  always_comb begin
    out_valid  = (state != EMPTY);
    skid_valid = (state == FULL);
    in_ready   = !skid_valid && !reset;
    accept     = in_valid && in_ready;
    load_new   = accept &&
                 ((state == EMPTY) ||
                  ((state == ONE) && out_ready));
    load_skid  = accept &&
                 (state == ONE) && !out_ready;
    pop_skid   = skid_valid && out_ready;
  end

  // output and skid data registers
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      if (load_new)
        out_q <= lane_data;
      else if (pop_skid)
        out_q <= skid_q;
      if (load_skid)
        skid_q <= lane_data;
    end
  end

  assign num_out = out_q;

endmodule

// File: doc/imm_extend_unit.md
Name: imm_extend_unit

Overview:
Pipelined, parametrised immediate extender for the decode stage. It generalises the single-select sign extender to four extension modes, configurable widths and broadcast to LANES vector lanes with a per-lane enable mask. It has a one-cycle registered datapath and valid/ready handshakes on both sides, with a skid buffer that sustains full throughput under back-pressure. It sits between the instruction decoder and the register-read/operand-mux stage.

Parameters:
IN_W, 26, width of the raw immediate field from the instruction
SHORT_W, 16, width of the short immediate, taken from num_in[SHORT_W-1:0]
DATA_W, 32, extended operand width
LANES, 4, number of vector lanes the result is broadcast to

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  upstream has a valid immediate
in_ready  out  1  block can accept this cycle
num_in  in  IN_W  raw immediate bits
imm_src  in  2  mode: 00 SEXT_SHORT, 01 SEXT_LONG, 10 ZEXT_SHORT, 11 UPPER
lane_en  in  LANES  per-lane enable; disabled lanes output zero
out_valid  out  1  num_out holds a valid result
out_ready  in  1  downstream accepts this cycle
num_out  out  LANES*DATA_W  lane i occupies bits [i*DATA_W +: DATA_W]

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port reset.
- Extension, computed combinationally from num_in and imm_src at acceptance:
  - SEXT_SHORT: replicate num_in[SHORT_W-1] above num_in[SHORT_W-1:0].
  - SEXT_LONG: replicate num_in[IN_W-1] above num_in[IN_W-1:0].
  - ZEXT_SHORT: zeros above num_in[SHORT_W-1:0].
  - UPPER: num_in[SHORT_W-1:0] placed in bits [DATA_W-1 : DATA_W-SHORT_W], with the low DATA_W-SHORT_W bits zero.
- Lane result = extended value if lane_en[i], else 0. lane_en is captured with num_in.
- Handshake:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
  - Once out_valid is high, num_out must stay stable until the output transfer.
- Latency: an input accepted at edge N appears on num_out with out_valid=1 after edge N. Throughput is 1/cycle while out_ready=1.
- Storage is an output register plus a one-entry skid register.
- States:
  - EMPTY: out_valid=0, skid empty.
  - ONE: out_valid=1, skid empty.
  - FULL: out_valid=1, skid valid.
- in_ready = !skid_valid && !reset. It is combinational from state only and never depends on in_valid.
- Transitions:
  - EMPTY + accept -> ONE.
  - ONE + accept + out_ready -> ONE, with the output register replaced by the new data.
  - ONE + accept + !out_ready -> FULL, with the new data written to skid.
  - ONE + !accept + out_ready -> EMPTY.
  - FULL + out_ready -> ONE: skid moves to the output register, skid cleared. No accept is possible because in_ready=0.
  - FULL + !out_ready -> FULL, everything held.
- Order is preserved: the skid entry is always younger than the output register entry.
- Reset (including mid-transfer): at the next edge out_valid=0, skid_valid=0, num_out=0 and all pending data are discarded. in_ready=0 while reset is high and 1 in the first cycle after.
- Elaboration checks (fatal on violation): SHORT_W < IN_W <= DATA_W, LANES >= 1.

Decomposition:
- Package imm_ext_pkg holds:
  - typedef enum logic [1:0] imm_mode_t {SEXT_SHORT, SEXT_LONG, ZEXT_SHORT, UPPER};
  - state enum {EMPTY, ONE, FULL};
  - default width constants.
- One sub-module, imm_extend_core: purely combinational extension of one value for a given mode.
- imm_extend_unit instantiates imm_extend_core once and replicates/masks the result across lanes. The handshake and skid logic stay in the top.

Test Plan:
- Defaults, lane_en=4'hF, num_in=26'b01111111111111100001111000 (0x1FFF878), one transfer per mode:
  - SEXT_SHORT -> every lane 0xFFFFF878.
  - SEXT_LONG -> 0x01FFF878.
  - ZEXT_SHORT -> 0x0000F878.
  - UPPER -> 0xF8780000.
  - Each result has out_valid one cycle after acceptance.
- num_in=26'h2000005, SEXT_LONG, lane_en=4'b0101 -> lanes 0,2 = 0xFE000005, lanes 1,3 = 0.
- Back-pressure: stream values A,B,C with out_ready=0 after A:
  - A held on num_out, B in skid, in_ready=0 on the next cycle, C is stalled.
  - Raise out_ready -> A, B, C emerge in order, with no loss or duplication.
- Continuous stream of 8 values, out_ready=1, in_valid=1 -> 8 outputs in 8 consecutive cycles, in_ready never drops.
- Assert reset while in FULL -> next cycle out_valid=0, num_out=0, in_ready=0. After release, in_ready=1 and the first new input passes with 1-cycle latency.
- Random in_valid/out_ready toggling for 1000 cycles against a queue scoreboard -> all results match the model, and num_out is stable whenever out_valid && !out_ready.
